dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the datapath's data-memory request interface. The datapath acts as initiator: it issues a word address, a write enable and write data, and waits for a response. This block accepts one request at a time, inserts a configurable number of wait cycles to model slow memory, and then performs the access on internal word storage. It completes each request with a one-cycle response pulse, so the processor can be verified against non-zero-latency memory.

## Interface
- `WIDTH`, 32, data word width in bits
- `DEPTH`, 64, number of words in storage; must be a power of two
- `LATENCY`, 2, wait cycles between acceptance and commit; legal range 1..15
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  initiator presents a request
- `req_ready`  out  1  responder can accept a request this cycle
- `we`  in  1  1 = write, 0 = read; sampled on acceptance
- `a`  in  32  word address (not byte address); sampled on acceptance
- `wd`  in  WIDTH  write data; sampled on acceptance
- `rsp_valid`  out  1  one-cycle pulse marking request completion
- `rd`  out  WIDTH  read data, valid while `rsp_valid`=1
- `err`  out  1  address error, valid while `rsp_valid`=1

## Operation
- The control FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1 and `reset` = 0.
  - When `req_valid` & `req_ready`: latch `we`, `a` and `wd`, load the counter with `LATENCY`-1, go to WAIT.
- **WAIT**
  - If the counter ≠ 0, decrement it and stay in WAIT.
  - If the counter = 0, commit the access at this edge and go to RESP:
    - a write stores the latched `wd` at index `a[log2(DEPTH)-1:0]`;
    - a read loads `rd` from that index.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle, then go to IDLE.
  - There is no response backpressure; the initiator must sample the response in that cycle.
- `rd` holds its value outside RESP. A write response drives `rd` = 0.
- Request inputs are ignored outside IDLE. Changes to `a`, `wd` or `we` after acceptance have no effect.
- Address bits above `log2(DEPTH)` are ignored unless `DMEM_RESP_RANGE_CHECK_EN` is defined.

## Timing
- **Reset values:** state IDLE; `rsp_valid`=0, `rd`=0, `err`=0, counter=0; `req_ready`=0 while `reset`=1. Storage contents are not reset.
- **Latency:** if the request is accepted in cycle 0:
  - WAIT occupies cycles 1..`LATENCY`;
  - the commit happens at the end of cycle `LATENCY`;
  - `rsp_valid`=1 in cycle `LATENCY`+1;
  - `req_ready`=1 again in cycle `LATENCY`+2.
- **Throughput:** one request per `LATENCY`+2 cycles.
- **Read-after-write:** a read accepted after a write's response returns the written data.
- **Reset mid-operation:** reset wins over every other event at the same edge.
  - Reset asserted in any WAIT cycle, including the commit edge, aborts the request.
  - No write occurs and no response is issued; the FSM returns to IDLE.
- **`req_valid` during reset:** the request is not accepted and is not remembered.

## Configuration
- **`DMEM_RESP_RANGE_CHECK_EN` defined:**
  - if the latched `a` ≥ `DEPTH`, a write is suppressed and a read returns `rd`=0;
  - `err`=1 during RESP;
  - timing is unchanged.
- **Not defined:**
  - `err` is tied to 0;
  - the address wraps modulo `DEPTH`, so word `DEPTH`+3 aliases word 3.

## Structure
- **Shared package `dmem_resp_pkg`:**
  - state enum typedef (IDLE/WAIT/RESP);
  - `LATENCY_MAX`=15 and counter width 4;
  - the default `WIDTH` and `DEPTH` constants.
- **Sub-module `dmem_resp_ram`:**
  - single-port storage with synchronous write and synchronous read;
  - one enable, driven only on the commit edge.
- **Top level:** the FSM, the request latches, the counter and the range check.

## Test plan
- **Reset:** hold `reset`=1 for 3 cycles with `req_valid`=1.
  - Required: `req_ready`=0, `rsp_valid`=0, `rd`=0, `err`=0 throughout.
  - Required: no acceptance after release until `req_valid` is asserted again.
- **Write then read, `LATENCY`=2:**
  - Write `a`=5, `wd`=0xDEADBEEF, accepted in cycle 0 → `rsp_valid` in cycle 3 with `rd`=0, `req_ready` in cycle 4.
  - Then read `a`=5 → `rd`=0xDEADBEEF with `rsp_valid`.
- **Latency sweep:** `LATENCY`=1 and 15 → `rsp_valid` exactly `LATENCY`+1 cycles after acceptance. Back-to-back requests held valid are accepted every `LATENCY`+2 cycles.
- **Input hold:** change `a` and `wd` every cycle after acceptance of a write to `a`=7 with `wd`=0x11 → word 7 = 0x11 and no other word modified.
- **Reset abort:** write `a`=9, `wd`=0x55 over prior contents 0xAA; assert reset on the commit edge → no response, and a later read of 9 returns 0xAA.
- **Out-of-range address:** write `a`=64 with `DEPTH`=64, `wd`=0x77.
  - With the macro: `err`=1, and word 0 is unchanged.
  - Without the macro: `err`=0, and word 0 = 0x77.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem_responder slice.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 64;

endpackage

// File: rtl/dmem_resp_if.sv
// Data-memory request/response bundle between the datapath (master) and the responder (slave).
interface dmem_resp_if
    import dmem_resp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic             we;
    logic [31:0]      a;
    logic [WIDTH-1:0] wd;
    logic             rsp_valid;
    logic [WIDTH-1:0] rd;
    logic             err;

    modport master (
        output req_valid, we, a, wd,
        input  req_ready, rsp_valid, rd, err
    );

    modport slave (
        input  req_valid, we, a, wd,
        output req_ready, rsp_valid, rd, err
    );
endinterface

// File: rtl/dmem_resp_ram.sv
// Single-port word storage: synchronous write, synchronous read; a write returns zero on the read port.
module dmem_resp_ram
    import dmem_resp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd
);
    logic [WIDTH-1:0] mem [DEPTH];

    // storage array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wd;
        end
    end

    // read data register, holds between accesses
    always_ff @(posedge clk) begin
        if (reset) begin
            rd <= '0;
        end else if (en) begin
            rd <= we ? '0 : mem[addr];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Slow-memory responder: one request at a time, LATENCY wait cycles, one-cycle response pulse.
// Optional feature macro: DMEM_RESP_RANGE_CHECK_EN (flag and suppress addresses >= DEPTH).
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = 2
) (
    input  logic      clk,
    input  logic      reset,
    dmem_resp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef DMEM_RESP_RANGE_CHECK_EN
    localparam int ADDR_W = 32;
`else
    localparam int ADDR_W = AW;
`endif

    state_t           state_r;
    state_t           next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WIDTH-1:0] wd_r;
    logic             rspValid_r;
    logic             accept_s;
    logic             commit_s;
    logic             inRange_s;
    logic [WIDTH-1:0] ramRd_s;

    assign bus.req_ready = (state_r == ST_IDLE) && !reset;
    assign accept_s      = bus.req_valid && bus.req_ready;
    // reset on the commit edge must abort the write as well as the response
    assign commit_s      = (state_r == ST_WAIT) && (cnt_r == '0) && !reset;

`ifdef DMEM_RESP_RANGE_CHECK_EN
    logic err_r;
    assign inRange_s = (addr_r < 32'(DEPTH));
    assign bus.err   = err_r;
    assign bus.rd    = err_r ? '0 : ramRd_s;

    // error flag captured at commit, held with rd until the next commit
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (commit_s) begin
            err_r <= !inRange_s;
        end
    end
`else
    assign inRange_s = 1'b1;
    assign bus.err   = 1'b0;
    assign bus.rd    = ramRd_s;
`endif

    assign bus.rsp_valid = rspValid_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_s = ST_WAIT;
                else          next_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_r == '0) next_s = ST_RESP;
                else             next_s = ST_WAIT;
            end
            ST_RESP: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // request latches, wait counter and response pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= '0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wd_r       <= '0;
            rspValid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r   <= bus.we;
                addr_r <= bus.a[ADDR_W-1:0];
                wd_r   <= bus.wd;
                cnt_r  <= CNT_W'(LATENCY - 1);
            end else if ((state_r == ST_WAIT) && (cnt_r != '0)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            rspValid_r <= commit_s;
        end
    end

    dmem_resp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (commit_s && inRange_s),
        .we    (we_r),
        .addr  (addr_r[AW-1:0]),
        .wd    (wd_r),
        .rd    (ramRd_s)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random traffic against a word-array model.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    dmem_resp_if #(.WIDTH(32)) bus2 ();
    dmem_resp_if #(.WIDTH(32)) bus1 ();
    dmem_resp_if #(.WIDTH(32)) bus15 ();

    dmem_responder #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT)) u2  (.clk(clk), .reset(reset), .bus(bus2.slave));
    dmem_responder #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(1))   u1  (.clk(clk), .reset(reset), .bus(bus1.slave));
    dmem_responder #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(15))  u15 (.clk(clk), .reset(reset), .bus(bus15.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; inputs are scrambled every cycle after acceptance.
    task automatic transact(input logic w, input logic [31:0] addr, input logic [31:0] data, input string tag);
        int n;
        int idx;
        logic expErr;
        logic [31:0] expRd;
        idx = int'(addr % 32'(DEPTH));
`ifdef DMEM_RESP_RANGE_CHECK_EN
        expErr = (addr >= 32'(DEPTH));
`else
        expErr = 1'b0;
`endif
        if (w) begin
            expRd = 32'd0;
        end else begin
            expRd = expErr ? 32'd0 : model[idx];
        end
        check($sformatf("%s ready_before", tag), {31'd0, bus2.req_ready}, 32'd1);
        bus2.req_valid = 1'b1;
        bus2.we = w;
        bus2.a = addr;
        bus2.wd = data;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        for (n = 1; n <= 20; n++) begin
            if (bus2.rsp_valid) break;
            bus2.a = $urandom;
            bus2.wd = $urandom;
            bus2.we = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check($sformatf("%s rsp_cycle", tag), 32'(n), 32'(LAT + 1));
        check($sformatf("%s rd", tag), bus2.rd, expRd);
        check($sformatf("%s err", tag), {31'd0, bus2.err}, {31'd0, expErr});
        if (w && !expErr) model[idx] = data;
        @(posedge clk); #1;
        check($sformatf("%s rsp_single", tag), {31'd0, bus2.rsp_valid}, 32'd0);
        check($sformatf("%s ready_after", tag), {31'd0, bus2.req_ready}, 32'd1);
        check($sformatf("%s rd_hold", tag), bus2.rd, expRd);
        bus2.we = 1'b0;
        bus2.a = 32'd0;
        bus2.wd = 32'd0;
    endtask

    initial begin
        logic [31:0] addr;
        bus2.req_valid = 1'b1; bus2.we = 1'b1; bus2.a = 32'd3; bus2.wd = 32'h1234;
        bus1.req_valid = 1'b0; bus1.we = 1'b0; bus1.a = 32'd0; bus1.wd = 32'd0;
        bus15.req_valid = 1'b0; bus15.we = 1'b0; bus15.a = 32'd0; bus15.wd = 32'd0;

        // reset held three cycles with a pending request
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset%0d ready", i), {31'd0, bus2.req_ready}, 32'd0);
            check($sformatf("reset%0d rsp_valid", i), {31'd0, bus2.rsp_valid}, 32'd0);
            check($sformatf("reset%0d rd", i), bus2.rd, 32'd0);
            check($sformatf("reset%0d err", i), {31'd0, bus2.err}, 32'd0);
        end
        reset = 1'b0;
        bus2.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset%0d ready", i), {31'd0, bus2.req_ready}, 32'd1);
            check($sformatf("post_reset%0d rsp_valid", i), {31'd0, bus2.rsp_valid}, 32'd0);
        end

        // directed write then read
        transact(1'b1, 32'd5, 32'hDEADBEEF, "wr5");
        transact(1'b0, 32'd5, 32'd0, "rd5");

        // give every word a known value so later reads prove no stray writes
        for (int i = 0; i < DEPTH; i++) begin
            transact(1'b1, 32'(i), $urandom, $sformatf("init%0d", i));
        end

        // input hold: task scrambles a/wd/we after acceptance
        transact(1'b1, 32'd7, 32'h11, "hold_wr7");
        transact(1'b0, 32'd7, 32'd0, "hold_rd7");
        check("hold_model7", model[7], 32'h11);

        // reset abort on the commit edge
        transact(1'b1, 32'd9, 32'hAA, "abort_pre");
        bus2.req_valid = 1'b1; bus2.we = 1'b1; bus2.a = 32'd9; bus2.wd = 32'h55;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort rsp_in_reset", {31'd0, bus2.rsp_valid}, 32'd0);
        check("abort ready_in_reset", {31'd0, bus2.req_ready}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("abort%0d no_rsp", i), {31'd0, bus2.rsp_valid}, 32'd0);
            check($sformatf("abort%0d ready", i), {31'd0, bus2.req_ready}, 32'd1);
        end
        transact(1'b0, 32'd9, 32'd0, "abort_rd9");
        check("abort_model9", model[9], 32'hAA);

        // out-of-range write, then inspect word 0 and the aliased address
        transact(1'b1, 32'd64, 32'h77, "oor_wr64");
        transact(1'b0, 32'd0, 32'd0, "oor_rd0");
        transact(1'b0, 32'd64, 32'd0, "oor_rd64");

        // random traffic including aliasing and wide addresses
        for (int i = 0; i < 40; i++) begin
            addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
            transact(1'($urandom_range(0, 1)), addr, $urandom, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            transact(1'b0, 32'(i), 32'd0, $sformatf("final%0d", i));
        end

        // latency sweep: held-valid back-to-back writes on LATENCY=1 and LATENCY=15
        bus1.req_valid = 1'b1; bus1.we = 1'b1;
        bus15.req_valid = 1'b1; bus15.we = 1'b1;
        for (int c = 0; c < 3 * 17; c++) begin
            check($sformatf("lat1 c%0d ready", c), {31'd0, bus1.req_ready}, {31'd0, (c % 3) == 0});
            check($sformatf("lat1 c%0d rsp", c), {31'd0, bus1.rsp_valid}, {31'd0, (c % 3) == 2});
            check($sformatf("lat15 c%0d ready", c), {31'd0, bus15.req_ready}, {31'd0, (c % 17) == 0});
            check($sformatf("lat15 c%0d rsp", c), {31'd0, bus15.rsp_valid}, {31'd0, (c % 17) == 16});
            bus1.a = 32'($urandom_range(0, 63)); bus1.wd = $urandom;
            bus15.a = 32'($urandom_range(0, 63)); bus15.wd = $urandom;
            @(posedge clk); #1;
        end
        bus1.req_valid = 1'b0;
        bus15.req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
